// File: rtl/mux_n_to_1_reg_if.sv
// mux_n_to_1_reg_if
// Bundles the producer-side channels and the consumer-side output stage of
// mux_n_to_1_reg.
//   master : the environment (producers + consumer + mode/sel control)
//   slave  : the mux itself
// Signals:
//   mode      0 = select-steered, 1 = round-robin
//   sel       channel index used in mode 0
//   in_data   channel i at [i*WIDTH +: WIDTH]
//   in_valid  per-channel valid
//   in_ready  per-channel ready (combinational)
//   out_data  registered data
//   out_valid registered valid
//   out_ready consumer ready
//   out_src   channel that supplied out_data
//   xfer_cnt  saturating count of accepted input transfers
interface mux_n_to_1_reg_if #(
  parameter int WIDTH  = 16,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2
);
  logic                    mode;
  logic [SEL_W-1:0]        sel;
  logic [NUM_IN*WIDTH-1:0] in_data;
  logic [NUM_IN-1:0]       in_valid;
  logic [NUM_IN-1:0]       in_ready;
  logic [WIDTH-1:0]        out_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [SEL_W-1:0]        out_src;
  logic [15:0]             xfer_cnt;

  modport master (
    output mode, sel, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_src, xfer_cnt
  );

  modport slave (
    input  mode, sel, in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_src, xfer_cnt
  );
endinterface

// File: rtl/mux_n_to_1_reg.sv
// mux_n_to_1_reg
// Selects one of NUM_IN WIDTH-bit channels, either by an explicit select
// (mode 0) or by round-robin arbitration among valid channels (mode 1), and
// delivers it through a single registered valid/ready output stage.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  mux_n_to_1_reg_if.slave (channels, output stage, mode/sel, counter)
module mux_n_to_1_reg #(
  parameter int WIDTH  = 16,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2
) (
  input  logic            clk,
  input  logic            rst,
  mux_n_to_1_reg_if.slave bus
);

  logic [WIDTH-1:0] ch_data [NUM_IN];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_IN; gi++) begin : g_ch
      assign ch_data[gi] = bus.in_data[gi*WIDTH +: WIDTH];
    end
  endgenerate

  logic [SEL_W-1:0]  ptr_q, ptr_d;
  logic              out_valid_q, out_valid_d;
  logic [WIDTH-1:0]  out_data_q, out_data_d;
  logic [SEL_W-1:0]  out_src_q, out_src_d;
  logic [15:0]       xfer_cnt_q, xfer_cnt_d;

  logic              load;
  logic              xfer;
  logic              grant_any;
  logic [NUM_IN-1:0] grant;
  logic [SEL_W-1:0]  grant_idx;

  // The output register may take a word when empty or when it drains now.
  assign load = !out_valid_q || bus.out_ready;
  assign xfer = load && grant_any;

  // Grant selection. Every grant implies the granted channel is valid.
  always_comb begin : grant_logic
    int cand;
    cand      = 0;
    grant     = '0;
    grant_any = 1'b0;
    grant_idx = '0;
    if (!bus.mode) begin
      // Loop compare instead of direct indexing keeps sel >= NUM_IN harmless.
      for (int i = 0; i < NUM_IN; i++) begin
        if (int'(bus.sel) == i && bus.in_valid[i]) begin
          grant[i]  = 1'b1;
          grant_any = 1'b1;
          grant_idx = SEL_W'(i);
        end
      end
    end else begin
      // Search ptr, ptr+1, ... wrapping at NUM_IN; first valid wins.
      for (int k = 0; k < NUM_IN; k++) begin
        cand = int'(ptr_q) + k;
        if (cand >= NUM_IN) cand = cand - NUM_IN;
        if (!grant_any && bus.in_valid[cand]) begin
          grant[cand] = 1'b1;
          grant_any   = 1'b1;
          grant_idx   = SEL_W'(cand);
        end
      end
    end
  end

  always_comb begin : next_state
    out_valid_d = load ? grant_any : out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    ptr_d       = ptr_q;
    xfer_cnt_d  = xfer_cnt_q;
    if (xfer) begin
      for (int i = 0; i < NUM_IN; i++) begin
        if (grant[i]) out_data_d = ch_data[i];
      end
      out_src_d = grant_idx;
      // Wrap explicitly at NUM_IN-1, which need not be a power of two.
      ptr_d = (int'(grant_idx) == NUM_IN - 1) ? '0 : grant_idx + SEL_W'(1);
      if (xfer_cnt_q != 16'hFFFF) xfer_cnt_d = xfer_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
      ptr_q       <= '0;
      xfer_cnt_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      ptr_q       <= ptr_d;
      xfer_cnt_q  <= xfer_cnt_d;
    end
  end

  assign bus.in_ready  = load ? grant : '0;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_src   = out_src_q;
  assign bus.xfer_cnt  = xfer_cnt_q;

endmodule

// File: tb/tb_mux_n_to_1_reg.sv
// tb_mux_n_to_1_reg
// Drives a 4-channel/16-bit instance and a 3-channel/8-bit instance side by
// side from a shared clock, comparing every cycle against a transaction-level
// reference model (grant search by modular arithmetic, plain state variables).
module tb_mux_n_to_1_reg;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mux_n_to_1_reg_if #(.WIDTH(16), .NUM_IN(4), .SEL_W(2)) bus4 ();
  mux_n_to_1_reg_if #(.WIDTH(8),  .NUM_IN(3), .SEL_W(2)) bus3 ();

  mux_n_to_1_reg #(.WIDTH(16), .NUM_IN(4), .SEL_W(2)) dut4 (
    .clk(clk), .rst(rst), .bus(bus4)
  );
  mux_n_to_1_reg #(.WIDTH(8), .NUM_IN(3), .SEL_W(2)) dut3 (
    .clk(clk), .rst(rst), .bus(bus3)
  );

  int checks_cnt = 0;
  int errors_cnt = 0;
  bit verbose    = 1'b1;

  // Stimulus per instance: index 0 = 4-channel, 1 = 3-channel.
  logic        mode_v  [2];
  logic [1:0]  sel_v   [2];
  logic [3:0]  valid_v [2];
  logic [15:0] data_v  [2][4];
  logic        ordy_v  [2];

  // Reference model state.
  int          m_ptr [2];
  logic        m_ov  [2];
  logic [15:0] m_od  [2];
  int          m_os  [2];
  logic [15:0] m_cnt [2];

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks_cnt++;
    if (act !== exp) begin
      errors_cnt++;
      $display("FAIL %s actual=%h expected=%h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int nin_of(int d);
    return (d == 0) ? 4 : 3;
  endfunction

  // Which channel wins this cycle, or -1.
  function automatic int ref_grant(int nin, logic mode, int sel, logic [3:0] valid, int ptr);
    if (!mode) return (sel < nin && valid[sel]) ? sel : -1;
    for (int k = 0; k < nin; k++) begin
      int c;
      c = (ptr + k) % nin;
      if (valid[c]) return c;
    end
    return -1;
  endfunction

  task automatic apply();
    bus4.mode      = mode_v[0];
    bus4.sel       = sel_v[0];
    bus4.in_valid  = valid_v[0];
    bus4.in_data   = {data_v[0][3], data_v[0][2], data_v[0][1], data_v[0][0]};
    bus4.out_ready = ordy_v[0];
    bus3.mode      = mode_v[1];
    bus3.sel       = sel_v[1];
    bus3.in_valid  = valid_v[1][2:0];
    bus3.in_data   = {data_v[1][2][7:0], data_v[1][1][7:0], data_v[1][0][7:0]};
    bus3.out_ready = ordy_v[1];
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_ptr[d] = 0; m_ov[d] = 1'b0; m_od[d] = '0; m_os[d] = 0; m_cnt[d] = '0;
    end
  endtask

  task automatic check_outputs(input string pfx);
    check_val({pfx, " d0 out_valid"}, 32'(bus4.out_valid), 32'(m_ov[0]));
    check_val({pfx, " d0 out_data"},  32'(bus4.out_data),  32'(m_od[0]));
    check_val({pfx, " d0 out_src"},   32'(bus4.out_src),   32'(m_os[0]));
    check_val({pfx, " d0 xfer_cnt"},  32'(bus4.xfer_cnt),  32'(m_cnt[0]));
    check_val({pfx, " d1 out_valid"}, 32'(bus3.out_valid), 32'(m_ov[1]));
    check_val({pfx, " d1 out_data"},  32'(bus3.out_data),  32'(m_od[1]));
    check_val({pfx, " d1 out_src"},   32'(bus3.out_src),   32'(m_os[1]));
    check_val({pfx, " d1 xfer_cnt"},  32'(bus3.xfer_cnt),  32'(m_cnt[1]));
  endtask

  // One clock cycle: inputs already applied; check ready, advance model, check outputs.
  task automatic tick();
    int   g [2];
    logic ld [2];
    #1;
    for (int d = 0; d < 2; d++) begin
      logic [3:0] exp_rdy;
      g[d]    = ref_grant(nin_of(d), mode_v[d], int'(sel_v[d]), valid_v[d], m_ptr[d]);
      ld[d]   = !m_ov[d] || ordy_v[d];
      exp_rdy = (ld[d] && g[d] >= 0) ? 4'(1 << g[d]) : 4'b0;
      if (d == 0) check_val("d0 in_ready", 32'(bus4.in_ready), 32'(exp_rdy));
      else        check_val("d1 in_ready", 32'(bus3.in_ready), 32'(exp_rdy));
    end
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      if (ld[d]) begin
        if (g[d] >= 0) begin
          m_ov[d]  = 1'b1;
          m_od[d]  = data_v[d][g[d]];
          m_os[d]  = g[d];
          m_ptr[d] = (g[d] + 1) % nin_of(d);
          if (m_cnt[d] != 16'hFFFF) m_cnt[d] = m_cnt[d] + 16'd1;
          if (verbose)
            $display("[%0t] d%0d xfer ch%0d data=%h cnt=%0d", $time, d, g[d], m_od[d], m_cnt[d]);
        end else begin
          m_ov[d] = 1'b0;
        end
      end
    end
    check_outputs("cyc");
  endtask

  task automatic async_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs("rst");
    @(posedge clk);
    #1;
    check_outputs("rst hold");
    rst = 1'b0;
  endtask

  task automatic set_all(input int d, input logic mode, input logic [1:0] sel,
                         input logic [3:0] valid, input logic ordy);
    mode_v[d] = mode; sel_v[d] = sel; valid_v[d] = valid; ordy_v[d] = ordy;
  endtask

  initial begin
    logic [15:0] held;
    for (int d = 0; d < 2; d++) begin
      set_all(d, 1'b0, 2'd0, 4'b0, 1'b1);
      for (int i = 0; i < 4; i++) data_v[d][i] = '0;
    end
    apply();
    async_reset();

    // Round-robin fairness: all valid, consumer always ready.
    for (int i = 0; i < 4; i++) begin
      data_v[0][i] = 16'hA000 + 16'(i);
      data_v[1][i] = 16'h00A0 + 16'(i);
    end
    set_all(0, 1'b1, 2'd0, 4'b1111, 1'b1);
    set_all(1, 1'b1, 2'd0, 4'b0111, 1'b1);
    apply();
    for (int i = 0; i < 5; i++) begin
      tick();
      check_val("rr src", 32'(bus4.out_src), 32'(i % 4));
      check_val("rr valid", 32'(bus4.out_valid), 32'd1);
    end
    check_val("rr cnt", 32'(bus4.xfer_cnt), 32'd5);

    // Mode 0 steering, then an out-of-range/idle select.
    data_v[0][0] = 16'h1111; data_v[0][1] = 16'h2222;
    set_all(0, 1'b0, 2'd1, 4'b0011, 1'b1);
    set_all(1, 1'b0, 2'd3, 4'b0011, 1'b1);
    apply();
    tick();
    check_val("steer data", 32'(bus4.out_data), 32'h2222);
    check_val("steer src", 32'(bus4.out_src), 32'd1);
    sel_v[0] = 2'd3;
    apply();
    tick();
    check_val("steer idle valid", 32'(bus4.out_valid), 32'd0);

    // Backpressure: load a word, stall 3 cycles, then release with a new grant.
    set_all(0, 1'b0, 2'd2, 4'b0100, 1'b1);
    data_v[0][2] = 16'hBEEF;
    apply();
    tick();
    held = bus4.out_data;
    ordy_v[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      data_v[0][2] = 16'hC000 + 16'(i);
      apply();
      tick();
      check_val("bp hold data", 32'(bus4.out_data), 32'(held));
    end
    ordy_v[0] = 1'b1;
    apply();
    tick();
    check_val("bp no bubble", 32'(bus4.out_valid), 32'd1);
    check_val("bp new data", 32'(bus4.out_data), 32'hC002);

    // Wrap and skip on the 3-channel instance: reach ptr=2, then 001, 100, 111.
    set_all(1, 1'b1, 2'd0, 4'b0010, 1'b1);
    apply(); tick();
    valid_v[1] = 4'b0001; apply(); tick();
    check_val("wrap grant ch0", 32'(bus3.out_src), 32'd0);
    valid_v[1] = 4'b0100; apply(); tick();
    check_val("skip grant ch2", 32'(bus3.out_src), 32'd2);
    valid_v[1] = 4'b0111; apply(); tick();
    check_val("wrap ptr to 0", 32'(bus3.out_src), 32'd0);

    // Mid-stream reset with out_valid=1 and ptr=2 on the 4-channel instance.
    async_reset();
    set_all(0, 1'b1, 2'd0, 4'b1111, 1'b1);
    apply(); tick(); tick();
    check_val("pre-rst ptr2 src", 32'(bus4.out_src), 32'd1);
    ordy_v[0] = 1'b0; apply();
    #2;
    async_reset();
    ordy_v[0] = 1'b1; apply();
    tick();
    check_val("post-rst ptr0", 32'(bus4.out_src), 32'd0);

    // Randomized traffic, including sel values beyond the 3-channel range.
    for (int n = 0; n < 1500; n++) begin
      for (int d = 0; d < 2; d++) begin
        mode_v[d]  = 1'($urandom_range(0, 1));
        sel_v[d]   = 2'($urandom_range(0, 3));
        valid_v[d] = 4'($urandom_range(0, 15));
        if (d == 1) valid_v[d][3] = 1'b0;
        ordy_v[d]  = ($urandom_range(0, 3) != 0);
        for (int i = 0; i < 4; i++)
          data_v[d][i] = (d == 0) ? 16'($urandom) : 16'($urandom_range(0, 255));
      end
      apply();
      tick();
    end

    // Counter saturation: continuous transfers until the count hits 16'hFFFF.
    verbose = 1'b0;
    set_all(0, 1'b1, 2'd0, 4'b1111, 1'b1);
    set_all(1, 1'b1, 2'd0, 4'b0111, 1'b1);
    apply();
    for (int n = 0; n < 70000 && (m_cnt[0] != 16'hFFFF || m_cnt[1] != 16'hFFFF); n++) tick();
    verbose = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check_val("sat d0", 32'(bus4.xfer_cnt), 32'hFFFF);
    check_val("sat d1", 32'(bus3.xfer_cnt), 32'hFFFF);

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
